atr_gpio_ctrl: RTL and testbench

ATR_GPIO_CTRL -- requirements
Module: atr_gpio_ctrl

---
 rtl/atr_gpio_pkg.sv | 27 ++
 rtl/atr_seq.sv | 71 +++++++
 rtl/atr_gpio_ctrl.sv | 134 +++++++++++++
 tb/tb_atr_gpio_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atr_gpio_pkg.sv
// Shared encodings for the ATR GPIO controller: sequencer states, register
// offsets inside the settings-bus window, and CTRL bit positions.
package atr_gpio_pkg;

  typedef enum logic [1:0] {
    StRxIdle   = 2'd0,
    StTxDelay  = 2'd1,
    StTxActive = 2'd2,
    StRxDelay  = 2'd3
  } atr_state_e;

  // Per-bank offsets (bank b lives at BASE_ADDR + 4*b)
  localparam logic [1:0] OffIo    = 2'd0;
  localparam logic [1:0] OffMask  = 2'd1;
  localparam logic [1:0] OffTxVal = 2'd2;
  localparam logic [1:0] OffRxVal = 2'd3;

  // Global offsets (after the last bank)
  localparam logic [1:0] OffTxDelay = 2'd0;
  localparam logic [1:0] OffRxDelay = 2'd1;
  localparam logic [1:0] OffCtrl    = 2'd2;

  localparam int unsigned CtrlAtrEn   = 0;
  localparam int unsigned CtrlForceTx = 1;
  localparam int unsigned CtrlForceRx = 2;

endpackage

// File: rtl/atr_seq.sv
// ATR sequencer: tracks TX/RX phases of the radio and times the programmable
// turn-on and turn-off delays with a single down-counter.
module atr_seq
  import atr_gpio_pkg::*;
#(
  parameter int unsigned DLY_W = 12
) (
  input  logic             master_clk,
  input  logic             reset,
  input  logic             atr_en,
  input  logic             tx_empty,
  input  logic [DLY_W-1:0] tx_delay,
  input  logic [DLY_W-1:0] rx_delay,
  output atr_state_e       state
);

  atr_state_e       state_q;
  logic [DLY_W-1:0] cnt_q;

  assign state = state_q;

  // Delays are sampled only on entry to a delay state, so register writes
  // during a countdown take effect at the next load.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state_q <= StRxIdle;
      cnt_q   <= '0;
    end else if (!atr_en) begin
      state_q <= StRxIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StRxIdle: begin
          if (!tx_empty) begin
            state_q <= StTxDelay;
            cnt_q   <= tx_delay;
          end
        end
        StTxDelay: begin
          if (tx_empty) begin
            state_q <= StRxIdle;
          end else if (cnt_q == '0) begin
            state_q <= StTxActive;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StTxActive: begin
          if (tx_empty) begin
            state_q <= StRxDelay;
            cnt_q   <= rx_delay;
          end
        end
        StRxDelay: begin
          if (!tx_empty) begin
            state_q <= StTxActive;
          end else if (cnt_q == '0) begin
            state_q <= StRxIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StRxIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/atr_gpio_ctrl.sv
// ATR GPIO controller: settings-bus register file for NUM_BANKS GPIO banks,
// with pins switched between TX/RX values by the ATR sequencer.
module atr_gpio_ctrl
  import atr_gpio_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned IO_W      = 16,
  parameter int unsigned DLY_W     = 12,
  parameter logic [6:0]  BASE_ADDR = 7'd64
) (
  input  logic                      master_clk,
  input  logic                      reset,
  input  logic [6:0]                serial_addr,
  input  logic [31:0]               serial_data,
  input  logic                      serial_strobe,
  input  logic                      tx_empty,
  output logic [NUM_BANKS*IO_W-1:0] io_out,
  output logic                      transmit_now,
  output logic [1:0]                atr_state
);

  localparam logic [7:0] BankEnd = 8'(4 * NUM_BANKS);

  // Window-relative offset; bit 7 set means the address is below BASE_ADDR.
  logic [7:0] off;
  logic [7:0] goff;
  logic       bank_wr;
  logic       glob_wr;

  assign off     = {1'b0, serial_addr} - {1'b0, BASE_ADDR};
  assign goff    = off - BankEnd;
  assign bank_wr = serial_strobe & ~off[7] & (off < BankEnd);
  assign glob_wr = serial_strobe & ~off[7] & (off >= BankEnd) & (goff < 8'd3);

  logic [DLY_W-1:0] tx_delay_q;
  logic [DLY_W-1:0] rx_delay_q;
  logic [2:0]       ctrl_q;
  logic             transmit_now_q;

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      tx_delay_q <= '0;
      rx_delay_q <= '0;
      ctrl_q     <= '0;
    end else if (glob_wr) begin
      case (goff[1:0])
        OffTxDelay: tx_delay_q <= serial_data[DLY_W-1:0];
        OffRxDelay: rx_delay_q <= serial_data[DLY_W-1:0];
        OffCtrl:    ctrl_q     <= serial_data[2:0];
        default:    ;
      endcase
    end
  end

  atr_state_e state;

  atr_seq #(
    .DLY_W (DLY_W)
  ) u_seq (
    .master_clk (master_clk),
    .reset      (reset),
    .atr_en     (ctrl_q[CtrlAtrEn]),
    .tx_empty   (tx_empty),
    .tx_delay   (tx_delay_q),
    .rx_delay   (rx_delay_q),
    .state      (state)
  );

  assign atr_state = state;

  logic tx_sel;
  logic atr_any;

  assign tx_sel  = ctrl_q[CtrlForceTx] |
                   (~ctrl_q[CtrlForceRx] & ((state == StTxActive) | (state == StRxDelay)));
  assign atr_any = |ctrl_q;

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      transmit_now_q <= 1'b0;
    end else begin
      transmit_now_q <= tx_sel;
    end
  end

  assign transmit_now = transmit_now_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [IO_W-1:0] io_q;
    logic [IO_W-1:0] io_d;
    logic [IO_W-1:0] mask_q;
    logic [IO_W-1:0] txval_q;
    logic [IO_W-1:0] rxval_q;
    logic [IO_W-1:0] out_q;
    logic [IO_W-1:0] out_d;
    logic [IO_W-1:0] wmask;
    logic [IO_W-1:0] gate;
    logic [IO_W-1:0] sel;
    logic            hit;

    assign hit   = bank_wr & (off[6:2] == 5'(b));
    assign wmask = serial_data[16 +: IO_W];
    assign io_d  = (io_q & ~wmask) | (serial_data[IO_W-1:0] & wmask);

    // Output mux sees pre-write register values in the cycle of a write.
    assign gate  = mask_q & {IO_W{atr_any}};
    assign sel   = tx_sel ? txval_q : rxval_q;
    assign out_d = (gate & sel) | (~gate & io_q);

    always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
        io_q    <= '0;
        mask_q  <= '0;
        txval_q <= '0;
        rxval_q <= '0;
        out_q   <= '0;
      end else begin
        if (hit) begin
          case (off[1:0])
            OffIo:    io_q    <= io_d;
            OffMask:  mask_q  <= serial_data[IO_W-1:0];
            OffTxVal: txval_q <= serial_data[IO_W-1:0];
            OffRxVal: rxval_q <= serial_data[IO_W-1:0];
            default:  ;
          endcase
        end
        out_q <= out_d;
      end
    end

    assign io_out[b*IO_W +: IO_W] = out_q;
  end

endmodule

// File: tb/tb_atr_gpio_ctrl.sv
// Self-checking bench for atr_gpio_ctrl: directed scenarios with literal
// expectations plus a randomized run checked against a behavioural model.
module tb_atr_gpio_ctrl;

  localparam int NB   = 4;
  localparam int IOW  = 16;
  localparam int DW   = 12;
  localparam int BASE = 64;
  localparam int GLB  = BASE + 4 * NB;

  logic            clk;
  logic            reset;
  logic [6:0]      serial_addr;
  logic [31:0]     serial_data;
  logic            serial_strobe;
  logic            tx_empty;
  logic [NB*IOW-1:0] io_out;
  logic            transmit_now;
  logic [1:0]      atr_state;

  atr_gpio_ctrl #(
    .NUM_BANKS (NB),
    .IO_W      (IOW),
    .DLY_W     (DW),
    .BASE_ADDR (7'(BASE))
  ) dut (
    .master_clk    (clk),
    .reset         (reset),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .tx_empty      (tx_empty),
    .io_out        (io_out),
    .transmit_now  (transmit_now),
    .atr_state     (atr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  logic [15:0] m_io   [NB];
  logic [15:0] m_mask [NB];
  logic [15:0] m_tx   [NB];
  logic [15:0] m_rx   [NB];
  logic [11:0] m_txd, m_rxd;
  logic [2:0]  m_ctrl;
  logic [1:0]  m_st;
  int          m_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_io[b] = '0; m_mask[b] = '0; m_tx[b] = '0; m_rx[b] = '0;
    end
    m_txd = '0; m_rxd = '0; m_ctrl = '0; m_st = 2'd0; m_left = 0;
  endtask

  function automatic logic [63:0] model_io();
    logic [63:0] v;
    logic        txs;
    logic [15:0] g, s;
    v   = '0;
    txs = m_ctrl[1] | (!m_ctrl[2] && (m_st == 2'd2 || m_st == 2'd3));
    for (int b = 0; b < NB; b++) begin
      g = (m_ctrl != 3'd0) ? m_mask[b] : 16'h0;
      s = txs ? m_tx[b] : m_rx[b];
      v[b*16 +: 16] = (g & s) | (~g & m_io[b]);
    end
    return v;
  endfunction

  function automatic logic model_tn();
    return m_ctrl[1] | (!m_ctrl[2] && (m_st == 2'd2 || m_st == 2'd3));
  endfunction

  // m_left counts remaining dwell cycles in a delay phase after the current one.
  task automatic model_advance();
    int off;
    if (!m_ctrl[0]) begin
      m_st = 2'd0; m_left = 0;
    end else begin
      case (m_st)
        2'd0: if (!tx_empty) begin m_st = 2'd1; m_left = int'(m_txd); end
        2'd1: if (tx_empty) m_st = 2'd0;
              else if (m_left == 0) m_st = 2'd2;
              else m_left--;
        2'd2: if (tx_empty) begin m_st = 2'd3; m_left = int'(m_rxd); end
        default: if (!tx_empty) m_st = 2'd2;
                 else if (m_left == 0) m_st = 2'd0;
                 else m_left--;
      endcase
    end
    if (serial_strobe) begin
      off = int'(serial_addr) - BASE;
      if (off >= 0 && off < 4 * NB) begin
        case (off % 4)
          0: m_io[off/4] = (m_io[off/4] & ~serial_data[31:16]) |
                           (serial_data[15:0] & serial_data[31:16]);
          1: m_mask[off/4] = serial_data[15:0];
          2: m_tx[off/4]   = serial_data[15:0];
          default: m_rx[off/4] = serial_data[15:0];
        endcase
      end else if (off == 4 * NB) begin
        m_txd = serial_data[11:0];
      end else if (off == 4 * NB + 1) begin
        m_rxd = serial_data[11:0];
      end else if (off == 4 * NB + 2) begin
        m_ctrl = serial_data[2:0];
      end
    end
  endtask

  // One clock: predict, advance model, sample 1 time unit after the edge.
  task automatic tick();
    logic [63:0] eio;
    logic        etn;
    eio = model_io();
    etn = model_tn();
    model_advance();
    @(posedge clk);
    #1;
    check("io_out", io_out, eio);
    check("transmit_now", 64'(transmit_now), 64'(etn));
    check("atr_state", 64'(atr_state), 64'(m_st));
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    serial_addr   = 7'(addr);
    serial_data   = data;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    #2;
    check("rst_state", 64'(atr_state), 64'd0);
    check("rst_io", io_out, 64'd0);
    check("rst_tn", 64'(transmit_now), 64'd0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int r, a;
    logic [31:0] d;
    reset = 1'b1; serial_addr = '0; serial_data = '0; serial_strobe = 1'b0; tx_empty = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_io", io_out, 64'd0);
    check("reset_tn", 64'(transmit_now), 64'd0);
    check("reset_state", 64'(atr_state), 64'd0);
    reset = 1'b0;

    // Masked IO writes on bank 1
    wr(BASE + 4, 32'h00FF_1234);
    tick();
    check("io_masked_a", 64'(io_out[31:16]), 64'h0034);
    wr(BASE + 4, 32'hFF00_AB00);
    tick();
    check("io_masked_b", 64'(io_out[31:16]), 64'hAB34);

    // TX delay then TX_ACTIVE
    wr(BASE + 1, 32'h0000_FFFF);
    wr(BASE + 2, 32'h0000_AAAA);
    wr(BASE + 3, 32'h0000_5555);
    wr(GLB, 32'd3);
    wr(GLB + 1, 32'd2);
    wr(GLB + 2, 32'd1);
    tick();
    check("rx_idle_val", 64'(io_out[15:0]), 64'h5555);
    tx_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tx_delay_dwell", 64'(atr_state), 64'd1);
    end
    tick();
    check("tx_active", 64'(atr_state), 64'd2);
    check("tx_lag_tn", 64'(transmit_now), 64'd0);
    tick();
    check("tx_val", 64'(io_out[15:0]), 64'hAAAA);
    check("tx_tn", 64'(transmit_now), 64'd1);

    // RX delay then idle
    tx_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rx_delay_dwell", 64'(atr_state), 64'd3);
      check("rx_delay_val", 64'(io_out[15:0]), 64'hAAAA);
    end
    tick();
    check("rx_idle_back", 64'(atr_state), 64'd0);
    check("rx_idle_lag", 64'(io_out[15:0]), 64'hAAAA);
    tick();
    check("rx_val", 64'(io_out[15:0]), 64'h5555);

    // Re-arm from RX_DELAY
    tx_empty = 1'b0;
    repeat (6) tick();
    tx_empty = 1'b1;
    tick();
    tick();
    check("rearm_rxd", 64'(atr_state), 64'd3);
    tx_empty = 1'b0;
    tick();
    check("rearm_state", 64'(atr_state), 64'd2);
    check("rearm_val", 64'(io_out[15:0]), 64'hAAAA);
    tick();
    check("rearm_val2", 64'(io_out[15:0]), 64'hAAAA);

    // Abort during TX delay
    tx_empty = 1'b1;
    repeat (5) tick();
    wr(GLB, 32'd5);
    tx_empty = 1'b0;
    tick(); check("abort_tn0", 64'(transmit_now), 64'd0);
    tick(); check("abort_tn1", 64'(transmit_now), 64'd0);
    tx_empty = 1'b1;
    tick();
    check("abort_state", 64'(atr_state), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_tn", 64'(transmit_now), 64'd0);
    end

    // Force bits
    wr(GLB + 2, 32'd6);
    tick();
    check("force_tx_tn", 64'(transmit_now), 64'd1);
    check("force_tx_val", 64'(io_out[15:0]), 64'hAAAA);
    wr(GLB + 2, 32'd4);
    tick();
    check("force_rx_tn", 64'(transmit_now), 64'd0);
    check("force_rx_val", 64'(io_out[15:0]), 64'h5555);

    // Reset while transmitting
    wr(GLB + 2, 32'd1);
    wr(GLB, 32'd0);
    tx_empty = 1'b0;
    repeat (3) tick();
    check("pre_rst_tn", 64'(transmit_now), 64'd1);
    rst_pulse();
    wr(BASE, 32'h0000_FFFF);
    wr(GLB + 2, 32'd6);
    tick();
    check("post_rst_io", io_out, 64'd0);
    wr(GLB + 2, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 15) tx_empty = ~tx_empty;
      serial_data = $urandom;
      serial_addr = 7'($urandom);
      serial_strobe = 1'b0;
      r = $urandom_range(0, 299);
      if (r == 0) begin
        rst_pulse();
      end else if (r < 80) begin
        if (r < 8) a = $urandom_range(0, 127);
        else a = BASE - 2 + $urandom_range(0, 4 * NB + 6);
        d = $urandom;
        if (a == GLB || a == GLB + 1) d[11:0] = 12'($urandom_range(0, 5));
        if (a == GLB + 2) d[2:0] = ($urandom_range(0, 99) < 75) ? 3'd1 : 3'($urandom_range(0, 7));
        serial_addr   = 7'(a);
        serial_data   = d;
        serial_strobe = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
